// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle between two
// pipeline stages.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 205
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with 2-entry skid,
// registered in_ready, flush and stall counter.
module pipe_stage_skid #(
  parameter int DATA_W       = 205,
  parameter bit CLR_ON_FLUSH = 1'b1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_stage_skid_if.slave       up,
  pipe_stage_skid_if.master      dn,
  input  logic                   flush,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  state_t                 state_q;
  state_t                 state_d;
  logic [DATA_W-1:0]      main_q;
  logic [DATA_W-1:0]      main_d;
  logic [DATA_W-1:0]      skid_q;
  logic [DATA_W-1:0]      skid_d;
  logic                   in_ready_q;
  logic                   out_valid;
  logic                   in_fire;
  logic                   out_fire;
  logic [STALL_CNT_W-1:0] stall_q;

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = up.valid & in_ready_q;
  assign out_fire  = out_valid & dn.ready;

  // Next state and register contents; flush beats handshake
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      skid_d  = '0;
      if (CLR_ON_FLUSH) begin
        main_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            main_d  = up.data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = up.data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = up.data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State, data and ready registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Saturating count of stalled output cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (out_valid && !dn.ready
                 && stall_q != STALL_MAX) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign up.ready  = in_ready_q;
  assign dn.valid  = out_valid;
  assign dn.data   = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed tasks plus
// a random run checked against a scoreboard.
module tb_pipe_stage_skid;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic flush1;
  logic [1:0]  occ0;
  logic [1:0]  occ1;
  logic [15:0] stall0;
  logic [2:0]  stall1;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];

  pipe_stage_skid_if #(.DATA_W(DW)) up0 ();
  pipe_stage_skid_if #(.DATA_W(DW)) dn0 ();
  pipe_stage_skid_if #(.DATA_W(DW)) up1 ();
  pipe_stage_skid_if #(.DATA_W(DW)) dn1 ();

  pipe_stage_skid #(
    .DATA_W(DW),
    .CLR_ON_FLUSH(1'b1),
    .STALL_CNT_W(16)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .up(up0),
    .dn(dn0),
    .flush(flush),
    .occupancy(occ0),
    .stall_cnt(stall0)
  );

  pipe_stage_skid #(
    .DATA_W(DW),
    .CLR_ON_FLUSH(1'b0),
    .STALL_CNT_W(3)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .up(up1),
    .dn(dn1),
    .flush(flush1),
    .occupancy(occ1),
    .stall_cnt(stall1)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor for dut0, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      if (dn0.valid && dn0.ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got %h, expected none",
                   dn0.data);
        end else begin
          logic [DW-1:0] e;
          e = sb.pop_front();
          if (dn0.data !== e) begin
            errors++;
            $display("FAIL sb_data: got %h, expected %h",
                     dn0.data, e);
          end
        end
      end
      if (flush) begin
        sb.delete();
      end else if (up0.valid && up0.ready) begin
        sb.push_back(up0.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    up0.valid = 1'b1;
    up0.data  = 16'h001F;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (dn0.valid !== 1'b0 || up0.ready !== 1'b1
          || occ0 !== 2'd0 || stall0 !== 16'd0
          || dn0.data !== 16'h0) begin
        errors++;
        $display("FAIL reset: v=%b r=%b occ=%0d st=%0d d=%h, expected 0 1 0 0 0",
                 dn0.valid, up0.ready, occ0, stall0, dn0.data);
      end
    end
    up0.valid = 1'b0;
    sb.delete();
    rst = 1'b1;
    step();
  endtask

  task automatic test_stream();
    dn0.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up0.valid = 1'b1;
      up0.data  = 16'(i);
      step();
      checks++;
      if (dn0.valid !== 1'b1 || up0.ready !== 1'b1
          || dn0.data !== 16'(i)) begin
        errors++;
        $display("FAIL stream: v=%b r=%b d=%h, expected 1 1 %h",
                 dn0.valid, up0.ready, dn0.data, 16'(i));
      end
    end
    up0.valid = 1'b0;
    step();
    checks++;
    if (dn0.valid !== 1'b0 || occ0 !== 2'd0) begin
      errors++;
      $display("FAIL stream_end: v=%b occ=%0d, expected 0 0",
               dn0.valid, occ0);
    end
  endtask

  task automatic test_backpressure();
    dn0.ready = 1'b0;
    up0.valid = 1'b1;
    up0.data  = 16'h000A;
    step();
    checks++;
    if (occ0 !== 2'd1 || up0.ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_one: occ=%0d r=%b, expected 1 1",
               occ0, up0.ready);
    end
    up0.data = 16'h000B;
    step();
    checks++;
    if (occ0 !== 2'd2 || up0.ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_two: occ=%0d r=%b, expected 2 0",
               occ0, up0.ready);
    end
    up0.data = 16'h000C;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (occ0 !== 2'd2 || up0.ready !== 1'b0
          || dn0.valid !== 1'b1
          || dn0.data !== 16'h000A) begin
        errors++;
        $display("FAIL bp_hold: occ=%0d r=%b v=%b d=%h, expected 2 0 1 000a",
                 occ0, up0.ready, dn0.valid, dn0.data);
      end
    end
    checks++;
    if (stall0 !== 16'd6) begin
      errors++;
      $display("FAIL bp_stall: got %0d, expected 6", stall0);
    end
    dn0.ready = 1'b1;
    step();
    checks++;
    if (dn0.data !== 16'h000B || up0.ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_rel1: d=%h r=%b, expected 000b 1",
               dn0.data, up0.ready);
    end
    step();
    checks++;
    if (dn0.data !== 16'h000C || occ0 !== 2'd1) begin
      errors++;
      $display("FAIL bp_rel2: d=%h occ=%0d, expected 000c 1",
               dn0.data, occ0);
    end
    up0.valid = 1'b0;
    step();
    checks++;
    if (dn0.valid !== 1'b0 || stall0 !== 16'd6) begin
      errors++;
      $display("FAIL bp_drain: v=%b st=%0d, expected 0 6",
               dn0.valid, stall0);
    end
  endtask

  task automatic test_flush();
    dn0.ready = 1'b0;
    up0.valid = 1'b1;
    up0.data  = 16'h000A;
    step();
    up0.data = 16'h000B;
    step();
    up0.data = 16'h000D;
    flush    = 1'b1;
    step();
    flush     = 1'b0;
    up0.valid = 1'b0;
    checks++;
    if (dn0.valid !== 1'b0 || occ0 !== 2'd0
        || up0.ready !== 1'b1
        || dn0.data !== 16'h0) begin
      errors++;
      $display("FAIL flush: v=%b occ=%0d r=%b d=%h, expected 0 0 1 0000",
               dn0.valid, occ0, up0.ready, dn0.data);
    end
    checks++;
    if (stall0 !== 16'd8) begin
      errors++;
      $display("FAIL flush_stall: got %0d, expected 8", stall0);
    end
    dn0.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dn0.valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_dead: v=%b, expected 0",
                 dn0.valid);
      end
    end
  endtask

  task automatic test_flush_rst();
    dn0.ready = 1'b0;
    up0.valid = 1'b1;
    up0.data  = 16'h0055;
    step();
    up0.valid = 1'b0;
    step();
    flush = 1'b1;
    rst   = 1'b0;
    step();
    sb.delete();
    checks++;
    if (dn0.valid !== 1'b0 || occ0 !== 2'd0
        || up0.ready !== 1'b1 || stall0 !== 16'd0
        || dn0.data !== 16'h0) begin
      errors++;
      $display("FAIL flush_rst: v=%b occ=%0d r=%b st=%0d d=%h, expected 0 0 1 0 0000",
               dn0.valid, occ0, up0.ready, stall0, dn0.data);
    end
    flush = 1'b0;
    rst   = 1'b1;
    step();
  endtask

  task automatic test_saturate();
    dn1.ready = 1'b0;
    up1.valid = 1'b1;
    up1.data  = 16'h0077;
    step();
    up1.valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
    end
    checks++;
    if (stall1 !== 3'd7 || dn1.data !== 16'h0077
        || dn1.valid !== 1'b1) begin
      errors++;
      $display("FAIL sat: st=%0d d=%h v=%b, expected 7 0077 1",
               stall1, dn1.data, dn1.valid);
    end
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    checks++;
    if (dn1.valid !== 1'b0 || dn1.data !== 16'h0077
        || stall1 !== 3'd7 || occ1 !== 2'd0) begin
      errors++;
      $display("FAIL hold_flush: v=%b d=%h st=%0d occ=%0d, expected 0 0077 7 0",
               dn1.valid, dn1.data, stall1, occ1);
    end
  endtask

  task automatic test_random();
    int occ_m;
    int fi;
    int fo;
    int rerr;
    occ_m = 0;
    rerr  = 0;
    for (int i = 0; i < 10000; i++) begin
      up0.valid = 1'($urandom_range(0, 1));
      up0.data  = 16'($urandom);
      dn0.ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 63) == 0);
      fi = (up0.valid && occ_m != 2) ? 1 : 0;
      fo = (dn0.ready && occ_m != 0) ? 1 : 0;
      if (flush) occ_m = 0;
      else occ_m = occ_m + fi - fo;
      step();
      checks++;
      if (occ0 !== 2'(occ_m)
          || up0.ready !== (occ_m != 2)
          || dn0.valid !== (occ_m != 0)) begin
        errors++;
        rerr++;
        if (rerr < 20) begin
          $display("FAIL rand_ctl: occ=%0d r=%b v=%b, expected occ %0d",
                   occ0, up0.ready, dn0.valid, occ_m);
        end
      end
    end
    up0.valid = 1'b0;
    flush     = 1'b0;
    dn0.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    checks++;
    if (sb.size() != 0 || dn0.valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: left=%0d v=%b, expected 0 0",
               sb.size(), dn0.valid);
    end
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    flush1    = 1'b0;
    up0.valid = 1'b0;
    up0.data  = '0;
    dn0.ready = 1'b0;
    up1.valid = 1'b0;
    up1.data  = '0;
    dn1.ready = 1'b0;
    step();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_rst();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
